// File: rtl/base_tempo_pkg.sv
// Shared types and defaults for the timebase counter (contador_base_tempo).
package base_tempo_pkg;
    localparam int BT_WIDTH       = 13;
    localparam int BT_DEFAULT_TOP = 4999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } bt_state_t;
endpackage

// File: rtl/contador_base_tempo_if.sv
// Control, period-update and count signals of the timebase counter.
// Optional NumCiclos output is present when BASE_TEMPO_NUM_CICLOS_EN is defined.
interface contador_base_tempo_if #(parameter int WIDTH = base_tempo_pkg::BT_WIDTH);
    logic             start;
    logic             pause;
    logic             stop;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_top;
    logic             cfg_ready;
    logic [WIDTH-1:0] saida;
    logic             wrap;
    logic             running;
`ifdef BASE_TEMPO_NUM_CICLOS_EN
    logic [15:0]      num_ciclos;

    modport master (output start, pause, stop, cfg_valid, cfg_top,
                    input  cfg_ready, saida, wrap, running, num_ciclos);
    modport slave  (input  start, pause, stop, cfg_valid, cfg_top,
                    output cfg_ready, saida, wrap, running, num_ciclos);
`else
    modport master (output start, pause, stop, cfg_valid, cfg_top,
                    input  cfg_ready, saida, wrap, running);
    modport slave  (input  start, pause, stop, cfg_valid, cfg_top,
                    output cfg_ready, saida, wrap, running);
`endif
endinterface

// File: rtl/base_tempo_cfg.sv
// Top-value register with a one-deep shadow so period changes land only on a wrap
// (or immediately when the counter is not running).
module base_tempo_cfg
    import base_tempo_pkg::*;
#(
    parameter int WIDTH       = BT_WIDTH,
    parameter int DEFAULT_TOP = BT_DEFAULT_TOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_top,
    input  logic             direct,
    input  logic             wrap_evt,
    input  logic             apply_now,
    output logic [WIDTH-1:0] top,
    output logic             cfg_ready
);
    logic [WIDTH-1:0] pend;
    logic             pend_full;
    logic             accept;

    assign cfg_ready = !pend_full;
    assign accept    = cfg_valid && cfg_ready;

    // accept implies the shadow is empty, so the branches never compete
    always_ff @(negedge clk) begin
        if (rst) begin
            top       <= WIDTH'(DEFAULT_TOP);
            pend      <= '0;
            pend_full <= 1'b0;
        end else if (accept && direct) begin
            top <= cfg_top;
        end else if (accept) begin
            pend      <= cfg_top;
            pend_full <= 1'b1;
        end else if (pend_full && (wrap_evt || apply_now)) begin
            top       <= pend;
            pend_full <= 1'b0;
        end
    end
endmodule

// File: rtl/contador_base_tempo.sv
// Programmable free-running timebase with run/pause/stop and shadowed period updates.
// Define BASE_TEMPO_NUM_CICLOS_EN to add the saturating wrap counter num_ciclos.
module contador_base_tempo
    import base_tempo_pkg::*;
#(
    parameter int WIDTH       = BT_WIDTH,
    parameter int DEFAULT_TOP = BT_DEFAULT_TOP
) (
    input  logic                        clk,
    input  logic                        rst,
    contador_base_tempo_if.slave        bus
);
    bt_state_t        state;
    logic [WIDTH-1:0] saida;
    logic [WIDTH-1:0] top;
    logic             running;
    logic             wrap;
    logic             wrap_evt;
    logic             apply_now;
    logic             direct;

    assign wrap      = (state == RUN) && (saida == top);
    // the count only actually rolls over when the edge is not a stop/pause
    assign wrap_evt  = wrap && !bus.stop && !bus.pause;
    assign apply_now = bus.stop || (bus.pause && state == RUN);
    assign direct    = (state != RUN) || apply_now;

    base_tempo_cfg #(.WIDTH(WIDTH), .DEFAULT_TOP(DEFAULT_TOP)) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (bus.cfg_valid),
        .cfg_top   (bus.cfg_top),
        .direct    (direct),
        .wrap_evt  (wrap_evt),
        .apply_now (apply_now),
        .top       (top),
        .cfg_ready (bus.cfg_ready)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= IDLE;
            saida   <= '0;
            running <= 1'b0;
        end else if (bus.stop) begin
            state   <= IDLE;
            saida   <= '0;
            running <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else begin
                        saida <= wrap ? '0 : saida + 1'b1;
                    end
                end
                IDLE, PAUSED: begin
                    if (bus.start && !bus.pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.saida   = saida;
    assign bus.wrap    = wrap;
    assign bus.running = running;

`ifdef BASE_TEMPO_NUM_CICLOS_EN
    logic [15:0] num_ciclos;

    always_ff @(negedge clk) begin
        if (rst || bus.stop)
            num_ciclos <= '0;
        else if (wrap && num_ciclos != 16'hFFFF)
            num_ciclos <= num_ciclos + 16'd1;
    end

    assign bus.num_ciclos = num_ciclos;
`endif
endmodule

// File: tb/tb_contador_base_tempo.sv
// Bench for contador_base_tempo: vector table, directed scenarios and random stimulus vs. a reference model.
module tb_contador_base_tempo;
    localparam int W = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    contador_base_tempo_if #(.WIDTH(W)) bus();

    contador_base_tempo #(.WIDTH(W), .DEFAULT_TOP(4999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model: 0=idle 1=run 2=paused, pending update kept in a queue
    int m_state, m_cnt, m_top, m_num;
    int pend[$];

    function automatic bit m_wrap();
        return (m_state == 1) && (m_cnt == m_top);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_top = 4999; m_num = 0;
        pend.delete();
    endtask

    task automatic model_step(bit rs, bit st, bit pa, bit sp, bit cv, int ct);
        bit w, acc;
        if (rs) begin
            model_reset();
            return;
        end
        w   = m_wrap();
        acc = cv && (pend.size() == 0);
        if (sp) begin
            if (pend.size() != 0) m_top = pend.pop_front();
            if (acc) m_top = ct;
            m_state = 0; m_cnt = 0; m_num = 0;
        end else begin
            if (w && m_num < 65535) m_num++;
            if (m_state == 1 && pa) begin
                if (pend.size() != 0) m_top = pend.pop_front();
                if (acc) m_top = ct;
                m_state = 2;
            end else if (m_state == 1) begin
                if (w) begin
                    m_cnt = 0;
                    if (pend.size() != 0) m_top = pend.pop_front();
                end else begin
                    m_cnt++;
                end
                if (acc) pend.push_back(ct);
            end else begin
                if (acc) m_top = ct;
                if (st && !pa) m_state = 1;
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rs, bit st, bit pa, bit sp, bit cv, int ct);
        int a, e;
        @(posedge clk);
        if (chk_en) begin
            a = int'({bus.saida, bus.wrap, bus.running, bus.cfg_ready});
            e = int'({W'(m_cnt), m_wrap(), m_state == 1, pend.size() == 0});
            check("model_outs{saida,wrap,run,rdy}", a, e);
`ifdef BASE_TEMPO_NUM_CICLOS_EN
            check("model_num_ciclos", int'(bus.num_ciclos), m_num);
`endif
        end
        rst = rs; bus.start = st; bus.pause = pa; bus.stop = sp;
        bus.cfg_valid = cv; bus.cfg_top = W'(ct);
        model_step(rs, st, pa, sp, cv, ct);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_until_wrap(int maxc, output int n);
        n = 0;
        while (!bus.wrap && n < maxc) begin
            drive(0, 0, 0, 0, 0, 0);
            n++;
        end
    endtask

    typedef struct {
        bit st, pa, sp, cv;
        int ct;
        int e_saida;
        bit e_wrap, e_run, e_rdy;
    } vec_t;

    function automatic vec_t mk(bit st, bit pa, bit sp, bit cv, int ct,
                                int es, bit ew, bit er, bit ey);
        vec_t v;
        v.st = st; v.pa = pa; v.sp = sp; v.cv = cv; v.ct = ct;
        v.e_saida = es; v.e_wrap = ew; v.e_run = er; v.e_rdy = ey;
        return v;
    endfunction

    initial begin
        vec_t tbl[16];
        int n;

        bus.start = 0; bus.pause = 0; bus.stop = 0; bus.cfg_valid = 0; bus.cfg_top = '0;

        // reset state
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("reset_saida", int'(bus.saida), 0);
        check("reset_wrap", int'(bus.wrap), 0);
        check("reset_running", int'(bus.running), 0);
        check("reset_ready", int'(bus.cfg_ready), 1);

        // short-period vectors: {st,pa,sp,cv,ct} -> {saida,wrap,running,ready} after the edge
        tbl[0]  = mk(0, 0, 0, 1, 3, 0, 0, 0, 1);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 2, 0, 1, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 3, 1, 1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[6]  = mk(0, 0, 0, 1, 1, 1, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 2, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 3, 1, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 1, 1, 1);
        tbl[11] = mk(0, 1, 0, 0, 0, 1, 0, 0, 1);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 1, 1, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[14] = mk(1, 0, 1, 0, 0, 0, 0, 0, 1);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            drive(0, tbl[i].st, tbl[i].pa, tbl[i].sp, tbl[i].cv, tbl[i].ct);
            check($sformatf("vec%0d", i),
                  int'({bus.saida, bus.wrap, bus.running, bus.cfg_ready}),
                  int'({W'(tbl[i].e_saida), tbl[i].e_wrap, tbl[i].e_run, tbl[i].e_rdy}));
        end

        // default period: wrap at 4999, 5000 edges per period
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        run_until_wrap(6000, n);
        check("t1_first_wrap_cycles", n, 4999);
        check("t1_wrap_saida", int'(bus.saida), 4999);
        drive(0, 0, 0, 0, 0, 0);
        check("t1_after_wrap_saida", int'(bus.saida), 0);
        run_until_wrap(6000, n);
        check("t1_period", n + 1, 5000);

        // shadowed update offered mid-period lands at the next wrap
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(100);
        check("t2_saida100", int'(bus.saida), 100);
        drive(0, 0, 0, 0, 1, 9);
        check("t2_ready_low", int'(bus.cfg_ready), 0);
        run_until_wrap(6000, n);
        check("t2_old_period_end", int'(bus.saida), 4999);
        check("t2_ready_still_low", int'(bus.cfg_ready), 0);
        drive(0, 0, 0, 0, 0, 0);
        check("t2_ready_back", int'(bus.cfg_ready), 1);
        run_until_wrap(50, n);
        check("t2_new_wrap", n, 9);
        drive(0, 0, 0, 0, 0, 0);
        run_until_wrap(50, n);
        check("t2_new_period", n + 1, 10);

        // pause holds the count, resume continues from the next value
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(37);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 0, 0);
        check("t3_paused_saida", int'(bus.saida), 37);
        check("t3_paused_wrap", int'(bus.wrap), 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("t3_resumed", int'(bus.saida), 38);

        // stop beats start
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(500);
        drive(0, 1, 0, 1, 0, 0);
        check("t4_stop_saida", int'(bus.saida), 0);
        check("t4_stop_running", int'(bus.running), 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("t4_restart", int'(bus.saida), 1);

        // top = 0: saida pinned at 0, wrap every cycle
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(5);
        check("t5_saida", int'(bus.saida), 0);
        check("t5_wrap", int'(bus.wrap), 1);
`ifdef BASE_TEMPO_NUM_CICLOS_EN
        check("t5_num_ciclos", int'(bus.num_ciclos), 5);
`endif

        // reset discards a pending update
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(200);
        drive(0, 0, 0, 0, 1, 9);
        check("t6_ready_low", int'(bus.cfg_ready), 0);
        drive(1, 0, 0, 0, 0, 0);
        check("t6_reset_outs", int'({bus.saida, bus.wrap, bus.running, bus.cfg_ready}), 1);
        drive(0, 1, 0, 0, 0, 0);
        run_until_wrap(6000, n);
        check("t6_default_top", n, 4999);

        // random traffic with small tops so wraps happen often
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 20)));
        end
        drive(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
